mem_lsu_stage: RTL and testbench

Parametrised, handshaked memory stage that replaces the single-cycle combinational data-bus access. It sits between execute and writeback. It accepts one instruction at a time from execute and issues a registered data-bus request with byte-lane strobes and lane-aligned store data. The request is held until the bus answers; the block then sign- or zero-extends load data and presents a registered result to writeback. Misaligned or illegal accesses never reach the bus and are flagged instead.

---
 rtl/mem_lsu_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_lsu_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_stage.sv
// Handshaked memory stage between execute and writeback: one op in flight, registered
// bus request with lane strobes, registered (sign/zero-extended) writeback result.
module mem_lsu_stage #(
    parameter int XLEN  = 64,
    parameter int NBYTE = XLEN / 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_alu,
    input  logic [XLEN-1:0]    in_rs2,
    input  logic [1:0]         in_memrw,
    input  logic [1:0]         in_size,
    input  logic               in_unsigned,
    input  logic [1:0]         in_wbsel,
    output logic               dreq_valid,
    output logic [XLEN-1:0]    dreq_addr,
    output logic [1:0]         dreq_size,
    output logic [NBYTE-1:0]   dreq_strobe,
    output logic [XLEN-1:0]    dreq_data,
    input  logic               dresp_data_ok,
    input  logic [XLEN-1:0]    dresp_data,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_result,
    output logic               out_misaligned
);
    localparam int OFF_W = $clog2(NBYTE);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_reg, state_next;
    logic [XLEN-1:0]    pc_reg, pc_next;
    logic               unsigned_reg, unsigned_next;
    logic [1:0]         wbsel_reg, wbsel_next;
    logic               dreq_valid_reg, dreq_valid_next;
    logic [XLEN-1:0]    dreq_addr_reg, dreq_addr_next;
    logic [1:0]         dreq_size_reg, dreq_size_next;
    logic [NBYTE-1:0]   dreq_strobe_reg, dreq_strobe_next;
    logic [XLEN-1:0]    dreq_data_reg, dreq_data_next;
    logic               out_valid_reg, out_valid_next;
    logic [XLEN-1:0]    out_pc_reg, out_pc_next;
    logic [XLEN-1:0]    out_result_reg, out_result_next;
    logic               out_misaligned_reg, out_misaligned_next;

    logic [OFF_W-1:0]   in_off;
    logic [OFF_W-1:0]   align_bad;
    logic [NBYTE-1:0]   lane_hit;
    logic               is_mem, is_store, size_fits, legal;

    assign in_off    = in_alu[OFF_W-1:0];
    assign is_mem    = in_memrw[1];
    assign is_store  = (in_memrw == 2'b11);
    assign size_fits = (32'(in_size) <= 32'(OFF_W));
    assign legal     = size_fits && (align_bad == '0);

    genvar gi;
    generate
        // An offset bit below the size's alignment boundary makes the access misaligned.
        for (gi = 0; gi < OFF_W; gi++) begin : g_align
            assign align_bad[gi] = in_off[gi] && (32'(gi) < 32'(in_size));
        end
        for (gi = 0; gi < NBYTE; gi++) begin : g_lane
            assign lane_hit[gi] = (32'(gi) >= 32'(in_off)) &&
                                  (32'(gi) < 32'(in_off) + (32'd1 << in_size));
        end
    endgenerate

    // Load extraction: mask covers 2^size bytes; a shift of XLEN yields zero, so the
    // full-width case naturally produces an all-ones mask and no extension bits.
    logic [XLEN-1:0] load_raw, load_mask, load_top, load_val;
    logic            load_sign;

    assign load_raw  = dresp_data >> {dreq_addr_reg[OFF_W-1:0], 3'b000};
    assign load_mask = (XLEN'(1) << (32'd8 << dreq_size_reg)) - XLEN'(1);
    assign load_top  = load_mask & ~(load_mask >> 1);
    assign load_sign = (|(load_raw & load_top)) && !unsigned_reg;
    assign load_val  = (load_raw & load_mask) | (load_sign ? ~load_mask : '0);

    function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] mem_v,
                                               input logic [XLEN-1:0] alu_v,
                                               input logic [XLEN-1:0] pc_v);
        case (sel)
            2'b00:   return mem_v;
            2'b01:   return alu_v;
            2'b10:   return pc_v + XLEN'(4);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_next          = state_reg;
        pc_next             = pc_reg;
        unsigned_next       = unsigned_reg;
        wbsel_next          = wbsel_reg;
        dreq_valid_next     = dreq_valid_reg;
        dreq_addr_next      = dreq_addr_reg;
        dreq_size_next      = dreq_size_reg;
        dreq_strobe_next    = dreq_strobe_reg;
        dreq_data_next      = dreq_data_reg;
        out_valid_next      = 1'b0;
        out_pc_next         = out_pc_reg;
        out_result_next     = out_result_reg;
        out_misaligned_next = out_misaligned_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (is_mem && legal) begin
                        state_next       = BUSY;
                        pc_next          = in_pc;
                        unsigned_next    = in_unsigned;
                        wbsel_next       = in_wbsel;
                        dreq_valid_next  = 1'b1;
                        dreq_addr_next   = in_alu;
                        dreq_size_next   = in_size;
                        dreq_strobe_next = is_store ? lane_hit : '0;
                        dreq_data_next   = is_store ? (in_rs2 << {in_off, 3'b000}) : '0;
                    end else begin
                        out_valid_next      = 1'b1;
                        out_pc_next         = in_pc;
                        out_misaligned_next = is_mem;
                        out_result_next     = is_mem ? '0 : wb_mux(in_wbsel, '0, in_alu, in_pc);
                    end
                end
            end
            BUSY: begin
                if (dresp_data_ok) begin
                    state_next          = IDLE;
                    dreq_valid_next     = 1'b0;
                    out_valid_next      = 1'b1;
                    out_pc_next         = pc_reg;
                    out_misaligned_next = 1'b0;
                    // A non-zero strobe marks the op in flight as a store.
                    out_result_next     = wb_mux(wbsel_reg,
                                                 (|dreq_strobe_reg) ? '0 : load_val,
                                                 dreq_addr_reg, pc_reg);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            pc_reg             <= '0;
            unsigned_reg       <= 1'b0;
            wbsel_reg          <= '0;
            dreq_valid_reg     <= 1'b0;
            dreq_addr_reg      <= '0;
            dreq_size_reg      <= '0;
            dreq_strobe_reg    <= '0;
            dreq_data_reg      <= '0;
            out_valid_reg      <= 1'b0;
            out_pc_reg         <= '0;
            out_result_reg     <= '0;
            out_misaligned_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            pc_reg             <= pc_next;
            unsigned_reg       <= unsigned_next;
            wbsel_reg          <= wbsel_next;
            dreq_valid_reg     <= dreq_valid_next;
            dreq_addr_reg      <= dreq_addr_next;
            dreq_size_reg      <= dreq_size_next;
            dreq_strobe_reg    <= dreq_strobe_next;
            dreq_data_reg      <= dreq_data_next;
            out_valid_reg      <= out_valid_next;
            out_pc_reg         <= out_pc_next;
            out_result_reg     <= out_result_next;
            out_misaligned_reg <= out_misaligned_next;
        end
    end

    assign in_ready       = (state_reg == IDLE);
    assign dreq_valid     = dreq_valid_reg;
    assign dreq_addr      = dreq_addr_reg;
    assign dreq_size      = dreq_size_reg;
    assign dreq_strobe    = dreq_strobe_reg;
    assign dreq_data      = dreq_data_reg;
    assign out_valid      = out_valid_reg;
    assign out_pc         = out_pc_reg;
    assign out_result     = out_result_reg;
    assign out_misaligned = out_misaligned_reg;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage (XLEN=64): directed vector table, hand-written multi-cycle
// sequences, then randomized ops checked against a byte-level reference model.
module tb_mem_lsu_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0, in_alu = '0, in_rs2 = '0;
    logic [1:0]  in_memrw = '0, in_size = '0, in_wbsel = '0;
    logic        in_unsigned = 1'b0;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic        out_valid, out_misaligned;
    logic [63:0] out_pc, out_result;

    mem_lsu_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
        .in_rs2(in_rs2), .in_memrw(in_memrw), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_wbsel(in_wbsel),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
        .out_misaligned(out_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  memrw, size, wbsel;
        logic        uns;
        logic [63:0] pc, alu, rs2, rdata;
    } txn_t;

    typedef struct {
        logic        busy, mis;
        logic [7:0]  strobe;
        logic [63:0] data, result;
    } exp_t;

    typedef struct {
        logic        busy, outv, mis;
        logic [7:0]  strobe;
        logic [1:0]  size;
        logic [63:0] addr, data, result, pc;
    } obs_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] memrw, input logic [1:0] size, input logic uns,
                           input logic [1:0] wbsel, input logic [63:0] pc, input logic [63:0] alu,
                           input logic [63:0] rs2, input logic [63:0] rdata, input logic busy,
                           input logic [7:0] strobe, input logic [63:0] data,
                           input logic [63:0] result, input logic mis);
        vec_t v;
        v.t.memrw = memrw; v.t.size = size; v.t.uns = uns; v.t.wbsel = wbsel;
        v.t.pc = pc; v.t.alu = alu; v.t.rs2 = rs2; v.t.rdata = rdata;
        v.e.busy = busy; v.e.strobe = strobe; v.e.data = data;
        v.e.result = result; v.e.mis = mis;
        vq.push_back(v);
    endtask

    // Reference: picks bytes out of the bus word one at a time and applies the
    // writeback rules directly.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          nb, off;
        logic        mem, st, legal;
        logic [63:0] ld, memv;
        nb    = 1 << t.size;
        off   = int'(t.alu[2:0]);
        mem   = t.memrw[1];
        st    = (t.memrw == 2'b11);
        legal = (off % nb == 0) && (nb <= 8);
        e.busy = mem && legal;
        e.mis  = mem && !legal;
        e.strobe = '0;
        e.data   = '0;
        ld = '0;
        if (e.busy) begin
            for (int b = 0; b < nb; b++) ld[8*b +: 8] = t.rdata[8*(off+b) +: 8];
            if (!t.uns && nb < 8 && ld[8*nb-1]) ld = ld - (64'd1 << (8*nb));
            if (st) begin
                for (int b = 0; b < 8; b++) e.strobe[b] = (b >= off) && (b < off + nb);
                e.data = t.rs2 << (8*off);
            end
        end
        memv = (e.busy && !st) ? ld : 64'd0;
        case (t.wbsel)
            2'b00:   e.result = memv;
            2'b01:   e.result = t.alu;
            2'b10:   e.result = t.pc + 64'd4;
            default: e.result = 64'd0;
        endcase
        if (e.mis) e.result = 64'd0;
        return e;
    endfunction

    // Drives one op from IDLE, answers the bus after 'delay' extra cycles, and
    // returns with time at the output cycle (+1).
    task automatic run_txn(input txn_t t, input int delay, output obs_t o);
        o.busy = 0; o.outv = 0; o.mis = 0; o.strobe = '0; o.size = '0;
        o.addr = '0; o.data = '0; o.result = '0; o.pc = '0;
        in_valid = 1'b1; in_pc = t.pc; in_alu = t.alu; in_rs2 = t.rs2;
        in_memrw = t.memrw; in_size = t.size; in_unsigned = t.uns; in_wbsel = t.wbsel;
        @(posedge clk); #1;
        if (dreq_valid) begin
            o.busy = 1'b1; o.strobe = dreq_strobe; o.data = dreq_data;
            o.addr = dreq_addr; o.size = dreq_size;
            for (int d = 0; d <= delay; d++) begin
                check("wait_in_ready", {63'd0, in_ready}, 64'd0);
                check("wait_dreq_valid", {63'd0, dreq_valid}, 64'd1);
                check("wait_out_valid", {63'd0, out_valid}, 64'd0);
                // A different instruction offered while busy must be ignored.
                in_valid = 1'b1; in_memrw = 2'($urandom); in_wbsel = 2'($urandom);
                in_alu = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
                dresp_data_ok = (d == delay);
                dresp_data = (d == delay) ? t.rdata : {$urandom, $urandom};
                @(posedge clk); #1;
            end
            dresp_data_ok = 1'b0;
        end
        in_valid = 1'b0;
        o.outv = out_valid; o.result = out_result; o.mis = out_misaligned; o.pc = out_pc;
    endtask

    task automatic compare(input string tag, input txn_t t, input exp_t e, input obs_t o);
        check({tag, "_busy"}, {63'd0, o.busy}, {63'd0, e.busy});
        check({tag, "_strobe"}, {56'd0, o.strobe}, {56'd0, e.strobe});
        check({tag, "_data"}, o.data, e.data);
        if (e.busy) begin
            check({tag, "_addr"}, o.addr, t.alu);
            check({tag, "_size"}, {62'd0, o.size}, {62'd0, t.size});
        end
        check({tag, "_out_valid"}, {63'd0, o.outv}, 64'd1);
        check({tag, "_result"}, o.result, e.result);
        check({tag, "_misaligned"}, {63'd0, o.mis}, {63'd0, e.mis});
        check({tag, "_out_pc"}, o.pc, t.pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t t;
        exp_t e;
        obs_t o;

        // memrw size uns wb | pc alu rs2 rdata | busy strobe data result mis
        add_vec(2'b10, 2'd0, 1'b0, 2'b00, 64'h100, 64'h1003, 64'h0, 64'h8000_0000,
                1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        add_vec(2'b10, 2'd0, 1'b1, 2'b00, 64'h100, 64'h1003, 64'h0, 64'h8000_0000,
                1'b1, 8'h00, 64'h0, 64'h80, 1'b0);
        add_vec(2'b11, 2'd1, 1'b0, 2'b01, 64'h104, 64'h2006, 64'h1234, 64'h0,
                1'b1, 8'hC0, 64'h1234_0000_0000_0000, 64'h2006, 1'b0);
        add_vec(2'b10, 2'd2, 1'b0, 2'b01, 64'h108, 64'h2002, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
        add_vec(2'b00, 2'd0, 1'b0, 2'b10, 64'h8000_0000, 64'h55, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h8000_0004, 1'b0);
        add_vec(2'b01, 2'd3, 1'b0, 2'b01, 64'h10C, 64'hDEAD_BEEF, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'hDEAD_BEEF, 1'b0);
        add_vec(2'b00, 2'd0, 1'b0, 2'b11, 64'h110, 64'h77, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
        add_vec(2'b10, 2'd3, 1'b1, 2'b00, 64'h114, 64'h3000, 64'h0, 64'hF123_4567_89AB_CDEF,
                1'b1, 8'h00, 64'h0, 64'hF123_4567_89AB_CDEF, 1'b0);
        add_vec(2'b10, 2'd1, 1'b0, 2'b00, 64'h118, 64'h3002, 64'h0, 64'h0000_0000_9876_0000,
                1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_9876, 1'b0);
        add_vec(2'b10, 2'd2, 1'b1, 2'b00, 64'h11C, 64'h3004, 64'h0, 64'h8765_4321_0000_0000,
                1'b1, 8'h00, 64'h0, 64'h8765_4321, 1'b0);
        add_vec(2'b10, 2'd2, 1'b0, 2'b00, 64'h120, 64'h3004, 64'h0, 64'h8765_4321_0000_0000,
                1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0);
        add_vec(2'b11, 2'd3, 1'b0, 2'b00, 64'h124, 64'h4000, 64'h0102_0304_0506_0708, 64'h0,
                1'b1, 8'hFF, 64'h0102_0304_0506_0708, 64'h0, 1'b0);
        add_vec(2'b11, 2'd0, 1'b0, 2'b10, 64'h200, 64'h4005, 64'h1122_3344_5566_77AB, 64'h0,
                1'b1, 8'h20, 64'h6677_AB00_0000_0000, 64'h204, 1'b0);
        add_vec(2'b11, 2'd3, 1'b0, 2'b10, 64'h128, 64'h4004, 64'h1, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
        add_vec(2'b00, 2'd0, 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h2, 1'b0);

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("rst_dreq_addr", dreq_addr, 64'd0);
        check("rst_dreq_size", {62'd0, dreq_size}, 64'd0);
        check("rst_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
        check("rst_dreq_data", dreq_data, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_misaligned", {63'd0, out_misaligned}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            run_txn(vq[i].t, 0, o);
            compare($sformatf("vec%0d", i), vq[i].t, vq[i].e, o);
            $display("vec %0d: memrw=%b size=%0d alu=%h result=%h mis=%0d", i,
                     vq[i].t.memrw, vq[i].t.size, vq[i].t.alu, o.result, o.mis);
        end

        // Back-to-back non-memory ops
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_memrw = 2'b00; in_wbsel = 2'b10;
            in_pc = 64'h8000_0000 + 64'(8 * i);
            @(posedge clk); #1;
            check("b2b_out_valid", {63'd0, out_valid}, 64'd1);
            check("b2b_result", out_result, 64'h8000_0004 + 64'(8 * i));
            check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            $display("b2b %0d: result=%h", i, out_result);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drop", {63'd0, out_valid}, 64'd0);

        // Bus wait: response arrives in the fourth request cycle
        in_valid = 1'b1; in_memrw = 2'b11; in_size = 2'd2; in_unsigned = 1'b0;
        in_wbsel = 2'b01; in_pc = 64'h300; in_alu = 64'h5004; in_rs2 = 64'h1111_2222_CAFE_BABE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("wait_dreq_valid_h", {63'd0, dreq_valid}, 64'd1);
            check("wait_dreq_addr_h", dreq_addr, 64'h5004);
            check("wait_dreq_size_h", {62'd0, dreq_size}, 64'd2);
            check("wait_dreq_strobe_h", {56'd0, dreq_strobe}, 64'hF0);
            check("wait_dreq_data_h", dreq_data, 64'hCAFE_BABE_0000_0000);
            check("wait_in_ready_h", {63'd0, in_ready}, 64'd0);
            check("wait_out_valid_h", {63'd0, out_valid}, 64'd0);
            if (c == 4) begin
                dresp_data_ok = 1'b1;
                dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            @(posedge clk); #1;
        end
        dresp_data_ok = 1'b0;
        check("wait_done_valid", {63'd0, out_valid}, 64'd1);
        check("wait_done_result", out_result, 64'h5004);
        check("wait_done_pc", out_pc, 64'h300);
        check("wait_done_in_ready", {63'd0, in_ready}, 64'd1);
        check("wait_done_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        $display("bus wait: result=%h", out_result);
        @(posedge clk); #1;
        check("wait_done_drop", {63'd0, out_valid}, 64'd0);

        // Reset asserted mid-BUSY
        in_valid = 1'b1; in_memrw = 2'b10; in_size = 2'd3; in_wbsel = 2'b00;
        in_pc = 64'h400; in_alu = 64'h6000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rbusy_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rbusy_async_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("rbusy_async_out_valid", {63'd0, out_valid}, 64'd0);
        check("rbusy_async_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        dresp_data_ok = 1'b1; dresp_data = 64'h1234;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        check("rbusy_stray_out_valid", {63'd0, out_valid}, 64'd0);
        check("rbusy_stray_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("rbusy_in_ready", {63'd0, in_ready}, 64'd1);
        $display("reset in busy: dreq_valid=%0d out_valid=%0d", dreq_valid, out_valid);

        // Randomized ops against the reference model
        for (int i = 0; i < 250; i++) begin
            int delay;
            t.memrw = 2'($urandom_range(0, 3));
            t.size  = 2'($urandom_range(0, 3));
            t.uns   = 1'($urandom_range(0, 1));
            t.wbsel = 2'($urandom_range(0, 3));
            t.pc    = {$urandom, $urandom};
            t.alu   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) t.alu[2:0] = 3'd0;
            t.rs2   = {$urandom, $urandom};
            t.rdata = {$urandom, $urandom};
            delay   = int'($urandom_range(0, 3));
            e = model(t);
            run_txn(t, delay, o);
            compare("rnd", t, e, o);
            $display("rnd %0d: memrw=%b size=%0d alu=%h delay=%0d result=%h mis=%0d", i,
                     t.memrw, t.size, t.alu, delay, o.result, o.mis);
            if ($urandom_range(0, 3) == 0) begin
                dresp_data_ok = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                dresp_data_ok = 1'b0;
                check("rnd_idle_out_valid", {63'd0, out_valid}, 64'd0);
                check("rnd_idle_dreq_valid", {63'd0, dreq_valid}, 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
